// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types, config selectors and sine table generator for nco_multi
package nco_pkg;

  typedef enum logic [1:0] {
    NCO_SAW    = 2'd0,
    NCO_SQUARE = 2'd1,
    NCO_TRI    = 2'd2,
    NCO_SINE   = 2'd3
  } nco_mode_e;

  localparam logic [1:0] CFG_FTW  = 2'd0;
  localparam logic [1:0] CFG_POFF = 2'd1;
  localparam logic [1:0] CFG_MODE = 2'd2;

  localparam longint PI_Q30 = 64'sd3373259426;

  // round((2^(out_w-1)-1) * sin(pi/2 * (idx+0.5) / 2^lut_aw)) in Q30 fixed point (Taylor series)
  function automatic int sine_lut_entry(input int lut_aw, input int out_w, input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scale;
    x     = (PI_Q30 * longint'(2 * idx + 1)) >>> (lut_aw + 2);
    x2    = (x * x) >>> 30;
    term  = x;
    sum   = x;
    for (int k = 1; k <= 7; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    scale = longint'((1 << (out_w - 1)) - 1);
    return int'((scale * sum + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/nco_sine_lut.sv
// rtl/nco_sine_lut.sv - quarter-wave sine ROM with quadrant folding to a full offset-binary sample
module nco_sine_lut
  import nco_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int OUT_W  = 8
) (
  input  logic [LUT_AW+1:0] phase_top,
  output logic [OUT_W-1:0]  sample
);

  localparam int DEPTH = 2 ** LUT_AW;

  logic [OUT_W-2:0]  rom [DEPTH];
  logic [1:0]        quad;
  logic [LUT_AW-1:0] addr;
  logic [OUT_W-2:0]  mag;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int ENTRY = sine_lut_entry(LUT_AW, OUT_W, i);
    assign rom[i] = ENTRY[OUT_W-2:0];
  end

  // Odd quadrants read the table backwards; the lower half mirrors below mid-scale (M-1-v == ~v).
  always_comb begin
    quad   = phase_top[LUT_AW+1:LUT_AW];
    addr   = quad[0] ? ~phase_top[LUT_AW-1:0] : phase_top[LUT_AW-1:0];
    mag    = rom[addr];
    sample = quad[1] ? {1'b0, ~mag} : {1'b1, mag};
  end

endmodule

// File: rtl/nco_multi.sv
// rtl/nco_multi.sv - multi-channel NCO with double-buffered FTW, phase offset and waveform mode
module nco_multi
  import nco_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 6
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic                                         cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                   cfg_sel,
  input  logic [ACC_W-1:0]                             cfg_data,
  input  logic                                         update,
  input  logic                                         sync_clr,
  output logic [NUM_CH*OUT_W-1:0]                      wave_out,
  output logic                                         wave_valid,
  output logic [NUM_CH-1:0]                            msb_out
);

  // Only phase bits from the lowest one any waveform reads up to the MSB are kept.
  localparam int TRI_LSB = ACC_W - 1 - OUT_W;
  localparam int SIN_LSB = ACC_W - 2 - LUT_AW;
  localparam int PH_LSB  = (TRI_LSB < SIN_LSB) ? TRI_LSB : SIN_LSB;
  localparam int PH_W    = ACC_W - PH_LSB;
  localparam int PH_MSB  = PH_W - 1;

  logic [ACC_W-1:0] acc_q      [NUM_CH];
  logic [ACC_W-1:0] acc_d      [NUM_CH];
  logic [ACC_W-1:0] ftw_sh_q   [NUM_CH];
  logic [ACC_W-1:0] ftw_sh_d   [NUM_CH];
  logic [ACC_W-1:0] ftw_act_q  [NUM_CH];
  logic [ACC_W-1:0] ftw_act_d  [NUM_CH];
  logic [ACC_W-1:0] poff_sh_q  [NUM_CH];
  logic [ACC_W-1:0] poff_sh_d  [NUM_CH];
  logic [ACC_W-1:0] poff_act_q [NUM_CH];
  logic [ACC_W-1:0] poff_act_d [NUM_CH];
  nco_mode_e        mode_sh_q  [NUM_CH];
  nco_mode_e        mode_sh_d  [NUM_CH];
  nco_mode_e        mode_act_q [NUM_CH];
  nco_mode_e        mode_act_d [NUM_CH];
  logic [OUT_W-1:0] wave_q     [NUM_CH];
  logic [OUT_W-1:0] wave_d     [NUM_CH];
  logic [NUM_CH-1:0] msb_q;
  logic [NUM_CH-1:0] msb_d;
  logic              valid_q;
  logic              valid_d;

  logic [PH_W-1:0]  phase_hi [NUM_CH];
  logic [OUT_W-1:0] sine_s   [NUM_CH];
  logic [OUT_W-1:0] shape    [NUM_CH];
  logic             cfg_ch_ok;

  assign cfg_ch_ok = (int'(cfg_ch) < NUM_CH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign phase_hi[c] = PH_W'((acc_q[c] + poff_act_q[c]) >> PH_LSB);

    nco_sine_lut #(
      .LUT_AW (LUT_AW),
      .OUT_W  (OUT_W)
    ) u_sine (
      .phase_top (phase_hi[c][PH_MSB -: LUT_AW+2]),
      .sample    (sine_s[c])
    );

    always_comb begin
      shape[c] = phase_hi[c][PH_MSB -: OUT_W];
      case (mode_act_q[c])
        NCO_SAW:    shape[c] = phase_hi[c][PH_MSB -: OUT_W];
        NCO_SQUARE: shape[c] = {OUT_W{~phase_hi[c][PH_MSB]}};
        NCO_TRI:    shape[c] = phase_hi[c][PH_MSB] ? ~phase_hi[c][PH_MSB-1 -: OUT_W]
                                                   :  phase_hi[c][PH_MSB-1 -: OUT_W];
        NCO_SINE:   shape[c] = sine_s[c];
        default:    shape[c] = phase_hi[c][PH_MSB -: OUT_W];
      endcase
    end

    assign wave_out[c*OUT_W +: OUT_W] = wave_q[c];
  end

  always_comb begin
    ftw_sh_d   = ftw_sh_q;
    poff_sh_d  = poff_sh_q;
    mode_sh_d  = mode_sh_q;
    ftw_act_d  = ftw_act_q;
    poff_act_d = poff_act_q;
    mode_act_d = mode_act_q;
    acc_d      = acc_q;
    wave_d     = wave_q;
    msb_d      = msb_q;
    valid_d    = en && !sync_clr;

    if (cfg_we && cfg_ch_ok) begin
      case (cfg_sel)
        CFG_FTW:  ftw_sh_d[cfg_ch]  = cfg_data;
        CFG_POFF: poff_sh_d[cfg_ch] = cfg_data;
        CFG_MODE: mode_sh_d[cfg_ch] = nco_mode_e'(cfg_data[1:0]);
        default:  ;
      endcase
    end

    // Active copies take the shadow as it stood before any same-cycle write.
    if (update) begin
      ftw_act_d  = ftw_sh_q;
      poff_act_d = poff_sh_q;
      mode_act_d = mode_sh_q;
    end

    for (int c = 0; c < NUM_CH; c++) begin
      if (sync_clr) begin
        acc_d[c] = '0;
      end else if (en) begin
        acc_d[c]  = acc_q[c] + ftw_act_q[c];
        wave_d[c] = shape[c];
        msb_d[c]  = phase_hi[c][PH_MSB];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]      <= '0;
        ftw_sh_q[c]   <= '0;
        ftw_act_q[c]  <= '0;
        poff_sh_q[c]  <= '0;
        poff_act_q[c] <= '0;
        mode_sh_q[c]  <= NCO_SAW;
        mode_act_q[c] <= NCO_SAW;
        wave_q[c]     <= '0;
      end
      msb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ftw_sh_q   <= ftw_sh_d;
      ftw_act_q  <= ftw_act_d;
      poff_sh_q  <= poff_sh_d;
      poff_act_q <= poff_act_d;
      mode_sh_q  <= mode_sh_d;
      mode_act_q <= mode_act_d;
      wave_q     <= wave_d;
      msb_q      <= msb_d;
      valid_q    <= valid_d;
    end
  end

  assign wave_valid = valid_q;
  assign msb_out    = msb_q;

endmodule
